// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising memory controller.
package mem_ctrl_pkg;

  // data_op encodings (2'b11 behaves as OP_NONE)
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  // data_size encodings (2'b11 behaves as SZ_WORD)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // controller states
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_READ  = 2'b01;
  localparam logic [1:0] S_WRITE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  // number of RAM byte cycles an access of the given size needs
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load word.
module mem_load_ext
  import mem_ctrl_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] word,
  input  logic [1:0]     size,
  input  logic           sgn,
  output logic [LEN-1:0] ext
);

  // replicate the top bit of the loaded quantity when signed, zeros otherwise
  always_comb begin
    ext = word;
    case (size)
      SZ_BYTE: ext = {{(LEN-8){sgn & word[7]}}, word[7:0]};
      SZ_HALF: ext = {{(LEN-16){sgn & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and
// data loads/stores, serialising each access into byte cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [LEN-1:0]        if_inst,
  input  logic [1:0]            data_op,
  input  logic [1:0]            data_size,
  input  logic                  data_signed,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [LEN-1:0]        data_wdata,
  output logic                  data_done,
  output logic [LEN-1:0]        data_rdata,
  output logic                  mem_stall,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]     state;
  logic [2:0]     cnt;
  logic [2:0]     n_bytes;
  logic           last;
  logic           serve_data;
  logic [1:0]     sz;
  logic           sgn;
  logic [LEN-1:0] wbuf;
  logic [LEN-1:0] rbuf;
  logic [LEN-1:0] rbuf_next;
  logic [LEN-1:0] ext_word;
  logic           mem_wr_q;
  logic           data_req;

  assign data_req  = (data_op == OP_LOAD) || (data_op == OP_STORE);
  assign n_bytes   = byte_count(sz);
  assign last      = (cnt == n_bytes - 3'd1);
  assign mem_wr    = mem_wr_q & rdy_in;
  assign mem_stall = (if_req & ~if_done) | (data_req & ~data_done);

  // merge the byte arriving this cycle into its little-endian slot
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{cnt[1:0], 3'b000} +: 8] = mem_din;
  end

  mem_load_ext #(.LEN(LEN)) u_ext (
    .word (rbuf_next),
    .size (sz),
    .sgn  (sgn),
    .ext  (ext_word)
  );

  // transaction sequencer: accept, byte cycles, one-cycle completion pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      mem_a      <= '0;
      mem_dout   <= 8'h00;
      mem_wr_q   <= 1'b0;
      if_done    <= 1'b0;
      data_done  <= 1'b0;
      if_inst    <= '0;
      data_rdata <= '0;
    end else if (rdy_in) begin
      case (state)
        S_IDLE: begin
          // data access belongs to the older instruction, so it wins
          if (data_req) begin
            serve_data <= 1'b1;
            sz         <= data_size;
            sgn        <= data_signed;
            wbuf       <= data_wdata;
            rbuf       <= '0;
            cnt        <= 3'd0;
            mem_a      <= data_addr;
            if (data_op == OP_STORE) begin
              state    <= S_WRITE;
              mem_dout <= data_wdata[7:0];
              mem_wr_q <= 1'b1;
            end else begin
              state    <= S_READ;
            end
          end else if (if_req) begin
            serve_data <= 1'b0;
            sz         <= SZ_WORD;
            sgn        <= 1'b0;
            rbuf       <= '0;
            cnt        <= 3'd0;
            mem_a      <= if_addr;
            state      <= S_READ;
          end
        end
        S_READ: begin
          rbuf <= rbuf_next;
          if (last) begin
            state <= S_DONE;
            if (serve_data) begin
              data_done  <= 1'b1;
              data_rdata <= ext_word;
            end else begin
              if_done <= 1'b1;
              if_inst <= rbuf_next;
            end
          end else begin
            cnt   <= cnt + 3'd1;
            mem_a <= mem_a + A_ONE;
          end
        end
        S_WRITE: begin
          if (last) begin
            state     <= S_DONE;
            mem_wr_q  <= 1'b0;
            data_done <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= mem_a + A_ONE;
            mem_dout <= wbuf[{cnt[1:0] + 2'd1, 3'b000} +: 8];
            mem_wr_q <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          if_done   <= 1'b0;
          data_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised scoreboard bench for mem_ctrl with a byte-array reference model.
module tb_mem_ctrl;

  localparam int LEN   = 32;
  localparam int AW    = 17;
  localparam int MSIZE = 1 << AW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           rdy_in = 1'b1;
  logic           if_req = 1'b0;
  logic [AW-1:0]  if_addr = '0;
  logic           if_done;
  logic [LEN-1:0] if_inst;
  logic [1:0]     data_op = 2'b00;
  logic [1:0]     data_size = 2'b00;
  logic           data_signed = 1'b0;
  logic [AW-1:0]  data_addr = '0;
  logic [LEN-1:0] data_wdata = '0;
  logic           data_done;
  logic [LEN-1:0] data_rdata;
  logic           mem_stall;
  logic [7:0]     mem_din;
  logic [7:0]     mem_dout;
  logic [AW-1:0]  mem_a;
  logic           mem_wr;

  mem_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .data_op(data_op), .data_size(data_size), .data_signed(data_signed),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_done(data_done),
    .data_rdata(data_rdata), .mem_stall(mem_stall), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM environment and an independent reference copy of its contents
  logic [7:0] ram     [MSIZE];
  logic [7:0] ref_mem [MSIZE];

  assign mem_din = ram[mem_a];
  always @(posedge clk) if (mem_wr) ram[mem_a] <= mem_dout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_load;
    logic [31:0] val;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  exp_t        mon_e;
  logic [31:0] exp_last_rd = '0;
  bit          if_prev = 1'b0;
  bit          d_prev  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // expected load value from the reference bytes, little-endian, extended
  function automatic logic [31:0] ref_load(input logic [AW-1:0] a, input int n, input bit sg);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_mem[AW'(a + k)]) << (8 * k);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic int nbytes(input int kind, input logic [1:0] sz);
    if (kind == 0 || sz[1]) return 4;
    return (sz == 2'b01) ? 2 : 1;
  endfunction

  // monitor: pops an expectation on each rising done pulse
  always @(negedge clk) begin
    if (rst && if_done && !if_prev) begin
      if (if_q.size() == 0) fail_now("if_done_spurious");
      else begin
        mon_e = if_q.pop_front();
        check("if_inst", if_inst, mon_e.val);
      end
    end
    if (rst && data_done && !d_prev) begin
      if (d_q.size() == 0) fail_now("data_done_spurious");
      else begin
        mon_e = d_q.pop_front();
        check(mon_e.is_load ? "data_rdata_load" : "data_rdata_store", data_rdata, mon_e.val);
      end
    end
    if_prev = if_done;
    d_prev  = data_done;
  end

  // queue the expected outcome of one request and apply it to the model
  task automatic expect_txn(input int kind, input logic [1:0] sz, input bit sg,
                            input logic [AW-1:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    n = nbytes(kind, sz);
    if (kind == 2) begin
      for (int k = 0; k < n; k++) ref_mem[AW'(a + k)] = wd[8*k +: 8];
      e = '{1'b0, exp_last_rd};
      d_q.push_back(e);
    end else begin
      e = '{1'b1, ref_load(a, n, (kind == 1) && sg)};
      if (kind == 0) if_q.push_back(e);
      else begin
        d_q.push_back(e);
        exp_last_rd = e.val;
      end
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store. Called at a negedge with the DUT idle.
  task automatic do_txn(input int kind, input logic [1:0] sz, input bit sg,
                        input logic [AW-1:0] a, input logic [31:0] wd, input int stall_req);
    int n, cyc, eff, stall_len;
    bit ok_bus, ok_stall, hit;
    n = nbytes(kind, sz);
    stall_len = (n == 4) ? stall_req : 0;
    expect_txn(kind, sz, sg, a, wd);
    if (kind == 0) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      data_op = (kind == 1) ? 2'b01 : 2'b10;
      data_size = sz; data_signed = sg; data_addr = a; data_wdata = wd;
    end
    cyc = 0; eff = 0; ok_bus = 1'b1; ok_stall = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (rdy_in) eff++;
      @(negedge clk);
      hit = (kind == 0) ? if_done : data_done;
      if (hit) break;
      if (cyc > 60) begin
        fail_now("done_timeout");
        break;
      end
      if (!mem_stall) ok_stall = 1'b0;
      if (mem_a !== AW'(a + eff - 1)) ok_bus = 1'b0;
      if (mem_wr !== ((kind == 2) && rdy_in)) ok_bus = 1'b0;
      if (kind == 2 && eff >= 1 && eff <= 4 && mem_dout !== wd[8*(eff-1) +: 8]) ok_bus = 1'b0;
      if (stall_len > 0) rdy_in = !(cyc >= 2 && cyc < 2 + stall_len);
    end
    rdy_in = 1'b1;
    check("done_latency", cyc, n + 1 + stall_len);
    check("bus_sequence", {31'd0, ok_bus}, 32'd1);
    check("stall_while_busy", {31'd0, ok_stall}, 32'd1);
    check("stall_at_done", {31'd0, mem_stall}, 32'd0);
    if_req = 1'b0;
    data_op = 2'b00;
    @(negedge clk);
  endtask

  // wait for a done pulse, verifying mem_stall stays high meanwhile
  task automatic wait_done(input bit want_if, output int cyc, output bit ok_stall);
    cyc = 0; ok_stall = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (want_if ? if_done : data_done) break;
      if (cyc > 60) begin
        fail_now("done_timeout");
        break;
      end
      if (!mem_stall) ok_stall = 1'b0;
    end
  endtask

  initial begin
    int          cyc;
    bit          ok;
    int          bad_bytes;
    logic [31:0] wd;
    logic [AW-1:0] a;
    int          kind;

    for (int i = 0; i < MSIZE; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05; ram[17'h00102] = 8'h00; ram[17'h00103] = 8'h00;
    ram[17'h00180] = 8'h80;
    ram[17'h00190] = 8'h34; ram[17'h00191] = 8'hF2;
    for (int i = 17'h00100; i < 17'h00200; i++) ref_mem[i] = ram[i];

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_a", {15'd0, mem_a}, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_dones", {30'd0, if_done, data_done}, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    do_txn(0, 2'b10, 1'b0, 17'h00100, 32'h0, 0);
    do_txn(2, 2'b10, 1'b0, 17'h00200, 32'hDEADBEEF, 0);
    do_txn(1, 2'b10, 1'b0, 17'h00200, 32'h0, 0);
    do_txn(1, 2'b00, 1'b1, 17'h00180, 32'h0, 0);
    do_txn(1, 2'b00, 1'b0, 17'h00180, 32'h0, 0);
    do_txn(1, 2'b01, 1'b1, 17'h00190, 32'h0, 0);
    do_txn(1, 2'b01, 1'b0, 17'h00190, 32'h0, 0);
    do_txn(0, 2'b10, 1'b0, 17'h00100, 32'h0, 3);
    do_txn(0, 2'b10, 1'b0, 17'h1FFFE, 32'h0, 0);
    do_txn(2, 2'b01, 1'b0, 17'h1FFFF, 32'h0000A55A, 0);

    // simultaneous fetch and load: data first, fetch right after DONE/IDLE
    expect_txn(1, 2'b10, 1'b0, 17'h00104, 32'h0);
    expect_txn(0, 2'b10, 1'b0, 17'h00108, 32'h0);
    if_req = 1'b1; if_addr = 17'h00108;
    data_op = 2'b01; data_size = 2'b10; data_signed = 1'b0; data_addr = 17'h00104;
    wait_done(1'b0, cyc, ok);
    check("both_data_latency", cyc, 5);
    check("both_data_stall", {31'd0, ok}, 32'd1);
    check("both_no_if_done_yet", {31'd0, if_done}, 32'd0);
    check("both_stall_for_fetch", {31'd0, mem_stall}, 32'd1);
    data_op = 2'b00;
    wait_done(1'b1, cyc, ok);
    check("both_fetch_latency", cyc, 6);
    check("both_fetch_stall", {31'd0, ok}, 32'd1);
    if_req = 1'b0;
    @(negedge clk);

    // reset in the middle of a word store, after two bytes are written
    wd = 32'h11223344;
    data_op = 2'b10; data_size = 2'b10; data_addr = 17'h00300; data_wdata = wd;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; data_op = 2'b00;
    @(posedge clk); @(negedge clk);
    ref_mem[17'h00300] = wd[7:0];
    ref_mem[17'h00301] = wd[15:8];
    exp_last_rd = '0;
    check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_done", {30'd0, if_done, data_done}, 32'd0);
    check("rst_mid_mem_a", {15'd0, mem_a}, 32'd0);
    check("rst_mid_rdata", data_rdata, 32'd0);
    rst = 1'b1;
    do_txn(1, 2'b10, 1'b0, 17'h00300, 32'h0, 0);

    // randomised traffic around the address wrap point
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = AW'(32'h1FFF0 + $urandom_range(0, 31));
      wd = $urandom;
      do_txn(kind, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, wd,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    // final RAM image against the reference
    repeat (2) @(negedge clk);
    bad_bytes = 0;
    for (int i = 0; i < MSIZE; i++) if (ram[i] !== ref_mem[i]) bad_bytes++;
    check("ram_image_bad_bytes", bad_bytes, 0);
    check("if_queue_drained", if_q.size(), 0);
    check("data_queue_drained", d_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single 8-bit RAM port between instruction fetch (IF) and the MEM stage's data access (loads and stores).
- Serialises each 32/16/8-bit access into byte-wide RAM cycles.
- Reassembles load data, sign- or zero-extending it.
- Drives mem_stall to the hazard unit while any requester's access is outstanding.
- Sits between the cpu core and the RAM.

Parameters:
- LEN, 32, core data width.
- ADDR_WIDTH, 17, RAM byte-address width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- if_req  in  1  instruction fetch request (always word, unsigned).
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_done  out  1  one-cycle pulse; if_inst valid in that cycle.
- if_inst  out  LEN  fetched instruction.
- data_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
- data_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- data_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- data_addr  in  ADDR_WIDTH  load/store byte address.
- data_wdata  in  LEN  store data; the low bytes are used.
- data_done  out  1  one-cycle pulse; data_rdata valid in that cycle for loads.
- data_rdata  out  LEN  extended load result.
- mem_stall  out  1  (if_req & ~if_done) | (data_op is load/store & ~data_done); combinational.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address (registered).
- mem_wr  out  1  1 = write this cycle (registered).

Behaviour:
- Reset (rst==0 at an edge) aborts any transaction regardless of rdy_in. After reset:
  - state=IDLE.
  - mem_a, mem_dout, mem_wr, if_done, data_done, if_inst, data_rdata, and the byte counter are all 0.
- rdy_in==0:
  - Every register holds its value.
  - mem_wr is forced to 0 combinationally.
  - done pulses are held and do not repeat once rdy_in returns.
- States:
  - IDLE: no transaction in progress.
  - READ: byte reads in progress.
  - WRITE: byte writes in progress.
  - DONE: one cycle, then IDLE.
- Arbitration in IDLE:
  - A data request (load/store) wins over if_req, because the data request belongs to the older instruction.
  - The granted request's address, size, sign and wdata are latched at the accept edge.
  - A transaction in progress is never preempted; input changes after accept are ignored.
- Byte count n: 1 for byte, 2 for half, 4 for word or fetch.
- Bytes are little-endian: byte k is at address A+k, and k=0 is the LSB.
- Address arithmetic is modulo 2^ADDR_WIDTH, so 0x1FFFF+1 wraps to 0.
- RAM timing: mem_din carries the byte for the address held on mem_a one cycle earlier.
- READ:
  - The accept edge sets mem_a=A.
  - Each following edge advances mem_a and captures mem_din into byte slot k-1.
  - After n captures the state goes to DONE.
  - Latency is n+1 cycles from the accept edge to the done pulse: 5 for word, 3 for half, 2 for byte.
- WRITE:
  - The accept edge sets mem_a=A, mem_dout=byte0, mem_wr=1.
  - Each following edge presents the next byte.
  - After byte n-1 the state goes to DONE with mem_wr=0.
  - Latency is n+1 cycles.
- DONE:
  - Exactly one of if_done or data_done is high, according to the served requester.
  - if_inst or data_rdata is updated at the edge entering DONE and held until the next completion.
  - Stores do not change data_rdata.
- Load extension:
  - Byte load: bit 7 replicated into bits 31:8 if signed, zeros otherwise.
  - Half load: bit 15 replicated into bits 31:16 if signed, zeros otherwise.
  - Word load: no extension.
- Request persistence:
  - A request still asserted in the IDLE cycle after DONE starts a new transaction.
  - Requesters must drop or advance their request on seeing the done pulse.
- Simultaneous requests: data is served first; the fetch is served immediately after with no idle gap beyond the DONE cycle.
- Reset or a request arriving during DONE has no effect until IDLE, except that reset always takes priority.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - The data_op encodings (OP_NONE, OP_LOAD, OP_STORE).
  - The size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - The state encodings (S_IDLE, S_READ, S_WRITE, S_DONE).
- One sub-module, mem_load_ext: combinational sign/zero extension of the assembled word from size and signed.

Test Plan:
- if_req=1, if_addr=0x00100, RAM bytes 13 05 00 00 -> if_done pulses 5 cycles after accept, if_inst=0x00000513; mem_a sequence 100,101,102,103; mem_wr stays 0.
- data_op=store, size=word, addr=0x00200, wdata=0xDEADBEEF -> mem_wr=1 for 4 cycles writing EF,BE,AD,DE to 200..203; data_done on cycle 5.
- Load byte, signed, at an address holding 0x80 -> data_rdata=0xFFFFFF80; same load with signed=0 -> 0x00000080; half load, signed, of bytes 34 F2 -> 0xFFFFF234.
- if_req and data load asserted in the same cycle -> data served first (data_done), then DONE, then fetch accepted; mem_stall high throughout until if_done.
- rdy_in low for 3 cycles mid word read -> mem_a and the counter freeze, mem_wr=0; read completes with correct data 3 cycles late. Word fetch at 0x1FFFE -> mem_a 1FFFE,1FFFF,00000,00001.
- rst=0 during a word write after 2 bytes -> next cycle state IDLE, mem_wr=0, no done pulse; a subsequent request behaves normally.
